// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer
//   Issue/capture stage in front of the 16-bit combinational ALU and its
//   11-way result mux. It accepts one request over a valid/ready handshake and
//   registers the opcode and operands that drive the ALU. After a fixed settle
//   window it captures the 32-bit result and status flags into a response
//   register, which is held under a second valid/ready handshake.
//   Shift amounts are clamped to 16 and opcodes above 1010 are answered
//   immediately as illegal, so the ALU never sees an unbounded shift or an
//   undefined mux select.
//
// Parameters
//   EXEC_CYCLES  ALU settle cycles between operand launch and capture (1..15)
//   CNT_W        width of the completed-operation counter
//
// Ports
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_opcode, req_a, req_b    request opcode and operands
//   alu_opcode, alu_a, alu_b    registered ALU drive (alu_b clamped for shifts)
//   alu_result, alu_overflow    combinational ALU answer
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_zero, rsp_neg, rsp_ovf, rsp_illegal   captured response
//   op_count                    completed response handshakes, wraps
module alu_req_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  output logic [3:0]       alu_opcode,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  input  logic [31:0]      alu_result,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_ovf,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0]  SETTLE_INIT = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0]  OP_LAST     = 4'b1010;
  localparam logic [3:0]  OP_SHL      = 4'b0110;
  localparam logic [3:0]  OP_SHR      = 4'b0111;
  localparam logic [3:0]  OP_ADD      = 4'b1000;
  localparam logic [3:0]  OP_SUB      = 4'b1001;
  localparam logic [15:0] SHIFT_MAX   = 16'd16;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;

  logic       accept;
  logic       req_illegal;
  logic       req_shift;
  logic       settle_done;
  logic       drain;
  logic [15:0] req_b_bounded;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    req_illegal   = (req_opcode > OP_LAST);
    req_shift     = (req_opcode == OP_SHL) || (req_opcode == OP_SHR);
    req_b_bounded = (req_shift && (req_b > SHIFT_MAX)) ? SHIFT_MAX : req_b;
    accept        = req_valid && req_ready;
    settle_done   = (state == EXEC) && (settle_cnt == 4'd0);
    drain         = (state == HOLD) && rsp_ready;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = req_illegal ? HOLD : EXEC;
        end
      end
      EXEC: begin
        if (settle_cnt == 4'd0) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Drain returns to IDLE only; a new accept needs the following edge.
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = (state == IDLE) && rst_n;
  end

  // ---------------------------------------------------------------------------
  // ALU drive registers: loaded only on an accept edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (accept) begin
      alu_opcode <= req_opcode;
      alu_a      <= req_a;
      alu_b      <= req_b_bounded;
    end
  end

  // ---------------------------------------------------------------------------
  // Settle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (accept && !req_illegal) begin
      settle_cnt <= SETTLE_INIT;
    end else if ((state == EXEC) && (settle_cnt != 4'd0)) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response register and completion counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_neg     <= 1'b0;
      rsp_ovf     <= 1'b0;
      rsp_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      if (accept && req_illegal) begin
        // Illegal opcodes bypass the ALU and answer with a zero result.
        rsp_valid   <= 1'b1;
        rsp_result  <= '0;
        rsp_zero    <= 1'b1;
        rsp_neg     <= 1'b0;
        rsp_ovf     <= 1'b0;
        rsp_illegal <= 1'b1;
      end else if (settle_done) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= alu_result;
        rsp_zero    <= (alu_result == 32'd0);
        rsp_neg     <= alu_result[31];
        rsp_ovf     <= ((alu_opcode == OP_ADD) || (alu_opcode == OP_SUB)) ? alu_overflow : 1'b0;
        rsp_illegal <= 1'b0;
      end else if (drain) begin
        // Result and flags are kept after the handshake; only valid drops.
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule
